// File: rtl/wb_shared_bus.sv
// wb_shared_bus: Wishbone B3 classic shared-bus interconnect.
// It connects NUM_M masters to NUM_S slaves through a single shared bus.
// Masters are arbitrated round-robin, and every grant passes through one IDLE cycle.
// The slave is selected by the top address nibble of the granted master.
// An address above the last slave returns a registered err pulse.
// Optional macro WB_BUS_TIMEOUT_EN adds a watchdog. It forces err after TIMEOUT
// cycles of strobe without a response.
//
// state | meaning
// IDLE  | no grant; pick the next requester from the round-robin pointer
// GRANT | bus owned by gidx_q until its cyc drops

module wb_shared_bus #(
   parameter int NUM_M   = 2,
   parameter int NUM_S   = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_M-1:0]          m_cyc_i,
   input  logic [NUM_M-1:0]          m_stb_i,
   input  logic [NUM_M-1:0]          m_we_i,
   input  logic [NUM_M*(DW/8)-1:0]   m_sel_i,
   input  logic [NUM_M*AW-1:0]       m_adr_i,
   input  logic [NUM_M*DW-1:0]       m_dat_i,
   output logic [NUM_M*DW-1:0]       m_dat_o,
   output logic [NUM_M-1:0]          m_ack_o,
   output logic [NUM_M-1:0]          m_err_o,
   output logic [NUM_S-1:0]          s_cyc_o,
   output logic [NUM_S-1:0]          s_stb_o,
   output logic                      s_we_o,
   output logic [(DW/8)-1:0]         s_sel_o,
   output logic [AW-1:0]             s_adr_o,
   output logic [DW-1:0]             s_dat_o,
   input  logic [NUM_S*DW-1:0]       s_dat_i,
   input  logic [NUM_S-1:0]          s_ack_i,
   output logic [NUM_M-1:0]          gnt_o
);

   localparam int SW = DW / 8;
   localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   if (NUM_M < 1 || NUM_M > 8 || NUM_S < 1 || NUM_S > 16 ||
       TIMEOUT < 1 || TIMEOUT > 65535 || (DW % 8) != 0) begin : g_bad_param
      $error("wb_shared_bus: parameter out of range");
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [MW-1:0]   gidx_q, gidx_d;
   logic [MW-1:0]   ptr_q, ptr_d;
   logic [MW-1:0]   cand;
   logic            err_q, err_d;

   logic            g_cyc, g_stb, g_we;
   logic [SW-1:0]   g_sel;
   logic [AW-1:0]   g_adr;
   logic [DW-1:0]   g_dat;
   logic [3:0]      idx;
   logic            valid;
   logic [NUM_S-1:0] slv_oh;
   logic            slv_ack;
   logic [DW-1:0]   slv_dat;
   logic            ack_ok;

`ifdef WB_BUS_TIMEOUT_EN
   logic [15:0]     cnt_q, cnt_d, cnt_inc;
`endif

   // Granted master's view of the bus and the slave it addresses.
   always_comb begin
      g_cyc   = m_cyc_i[gidx_q];
      g_stb   = m_stb_i[gidx_q];
      g_we    = m_we_i[gidx_q];
      g_sel   = m_sel_i[gidx_q*SW +: SW];
      g_adr   = m_adr_i[gidx_q*AW +: AW];
      g_dat   = m_dat_i[gidx_q*DW +: DW];
      idx     = g_adr[AW-1 -: 4];
      valid   = (int'(idx) < NUM_S);
      slv_oh  = '0;
      slv_ack = 1'b0;
      slv_dat = '0;
      for (int s = 0; s < NUM_S; s++) begin
         if (valid && int'(idx) == s) begin
            slv_oh[s] = 1'b1;
            slv_ack   = s_ack_i[s];
            slv_dat   = s_dat_i[s*DW +: DW];
         end
      end
      // While err is on the wire, a late slave ack is swallowed so that
      // ack and err never meet.
      ack_ok = (state_q == GRANT) & g_stb & slv_ack & ~err_q;
   end

   // Next state: arbitration, release, and the registered err pulses.
   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      err_d   = 1'b0;
      cand    = '0;
`ifdef WB_BUS_TIMEOUT_EN
      cnt_d   = '0;
      cnt_inc = cnt_q + 16'd1;
`endif
      unique case (state_q)
         IDLE: begin
            if (|m_cyc_i) begin
               // Scan downward so that the requester closest to the pointer wins.
               for (int i = NUM_M - 1; i >= 0; i--) begin
                  cand = MW'((int'(ptr_q) + i) % NUM_M);
                  if (m_cyc_i[cand]) gidx_d = cand;
               end
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!g_cyc) begin
               state_d = IDLE;
               ptr_d   = MW'((int'(gidx_q) + 1) % NUM_M);
            end else begin
               err_d = g_stb & ~valid & ~err_q;
`ifdef WB_BUS_TIMEOUT_EN
               if (g_stb && valid && !ack_ok && !err_q) begin
                  if (cnt_inc == 16'(TIMEOUT)) begin
                     err_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gidx_q  <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

`ifdef WB_BUS_TIMEOUT_EN
   // Watchdog counter of unanswered strobe cycles.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`endif

   // Output muxing; everything is forced to zero while no grant is held or reset is asserted.
   always_comb begin
      gnt_o   = '0;
      s_cyc_o = '0;
      s_stb_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_dat_o = '0;
      if (!rst && state_q == GRANT) begin
         gnt_o[gidx_q]             = 1'b1;
         s_cyc_o                   = g_cyc ? slv_oh : '0;
         s_stb_o                   = g_stb ? slv_oh : '0;
         s_we_o                    = g_we;
         s_sel_o                   = g_sel;
         s_adr_o                   = g_adr;
         s_dat_o                   = g_dat;
         m_ack_o[gidx_q]           = ack_ok;
         m_err_o[gidx_q]           = err_q;
         m_dat_o[gidx_q*DW +: DW]  = slv_dat;
      end
   end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus. It drives directed scenarios and then random traffic.
// A transaction-level model of ownership, pointer and err pulses sets the expected values.
module tb_wb_shared_bus;

   localparam int NUM_M   = 2;
   localparam int NUM_S   = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int SW      = DW / 8;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NUM_M-1:0] b_cyc, b_stb, b_we;
   logic [SW-1:0]    b_sel  [NUM_M];
   logic [AW-1:0]    b_adr  [NUM_M];
   logic [DW-1:0]    b_wdat [NUM_M];
   logic [NUM_S-1:0] b_sack;
   logic [DW-1:0]    b_rdat [NUM_S];

   logic [NUM_M*SW-1:0] m_sel_v;
   logic [NUM_M*AW-1:0] m_adr_v;
   logic [NUM_M*DW-1:0] m_wdat_v;
   logic [NUM_S*DW-1:0] s_rdat_v;

   logic [NUM_M*DW-1:0] m_dat_o;
   logic [NUM_M-1:0]    m_ack_o, m_err_o, gnt_o;
   logic [NUM_S-1:0]    s_cyc_o, s_stb_o;
   logic                s_we_o;
   logic [SW-1:0]       s_sel_o;
   logic [AW-1:0]       s_adr_o;
   logic [DW-1:0]       s_dat_o;

   always_comb begin
      m_sel_v  = '0;
      m_adr_v  = '0;
      m_wdat_v = '0;
      for (int m = 0; m < NUM_M; m++) begin
         m_sel_v[m*SW +: SW]  = b_sel[m];
         m_adr_v[m*AW +: AW]  = b_adr[m];
         m_wdat_v[m*DW +: DW] = b_wdat[m];
      end
   end

   always_comb begin
      s_rdat_v = '0;
      for (int s = 0; s < NUM_S; s++) s_rdat_v[s*DW +: DW] = b_rdat[s];
   end

   wb_shared_bus #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we),
      .m_sel_i(m_sel_v), .m_adr_i(m_adr_v), .m_dat_i(m_wdat_v),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_rdat_v), .s_ack_i(b_sack), .gnt_o(gnt_o)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model: which master owns the bus, where round robin resumes,
   // whether an err is showing this cycle, and how long the strobe has waited.
   int owner = -1;
   int rr    = 0;
   bit err_now = 1'b0;
   int wait_cnt = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_ack();
      int idx;
      if (rst || owner < 0) return 1'b0;
      idx = int'(b_adr[owner][31:28]);
      if (idx >= NUM_S) return 1'b0;
      return b_stb[owner] && b_sack[idx] && !err_now;
   endfunction

   task automatic half();
      logic [NUM_M-1:0]    e_gnt, e_ack, e_err;
      logic [NUM_S-1:0]    e_scyc, e_sstb;
      logic [68:0]         e_sh;
      logic [NUM_M*DW-1:0] e_mdat;
      #4;
      e_gnt = '0; e_ack = '0; e_err = '0; e_scyc = '0; e_sstb = '0; e_sh = '0; e_mdat = '0;
      if (!rst && owner >= 0) begin
         int g;
         int idx;
         g   = owner;
         idx = int'(b_adr[g][31:28]);
         e_gnt[g] = 1'b1;
         e_sh = {b_we[g], b_sel[g], b_adr[g], b_wdat[g]};
         if (idx < NUM_S) begin
            if (b_cyc[g]) e_scyc[idx] = 1'b1;
            if (b_stb[g]) e_sstb[idx] = 1'b1;
            e_mdat[g*DW +: DW] = b_rdat[idx];
         end
         e_ack[g] = model_ack();
         e_err[g] = err_now;
      end
      chk("gnt", gnt_o, e_gnt);
      chk("s_cyc", s_cyc_o, e_scyc);
      chk("s_stb", s_stb_o, e_sstb);
      chk("s_shared", {s_we_o, s_sel_o, s_adr_o, s_dat_o}, e_sh);
      chk("m_ack", m_ack_o, e_ack);
      chk("m_err", m_err_o, e_err);
      chk("m_dat", m_dat_o, e_mdat);
   endtask

   task automatic edge_step();
      bit acked;
      acked = model_ack();
      @(posedge clk);
      if (rst) begin
         owner = -1; rr = 0; err_now = 1'b0; wait_cnt = 0;
      end else if (owner < 0) begin
         int found;
         found = -1;
         for (int i = 0; i < NUM_M; i++)
            if (found < 0 && b_cyc[(rr + i) % NUM_M]) found = (rr + i) % NUM_M;
         owner = found;
         err_now = 1'b0; wait_cnt = 0;
      end else if (!b_cyc[owner]) begin
         rr = (owner + 1) % NUM_M;
         owner = -1; err_now = 1'b0; wait_cnt = 0;
      end else begin
         bit valid, nerr;
         valid = int'(b_adr[owner][31:28]) < NUM_S;
         nerr  = !valid && b_stb[owner] && !err_now;
`ifdef WB_BUS_TIMEOUT_EN
         if (valid && b_stb[owner] && !acked && !err_now) begin
            wait_cnt++;
            if (wait_cnt == TIMEOUT) begin nerr = 1'b1; wait_cnt = 0; end
         end else wait_cnt = 0;
`endif
         err_now = nerr;
      end
      #1;
   endtask

   task automatic cycle();
      half();
      edge_step();
   endtask

   task automatic set_m(input int m, input bit c, input bit we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] d);
      b_cyc[m] = c; b_stb[m] = c; b_we[m] = we; b_sel[m] = sel; b_adr[m] = adr; b_wdat[m] = d;
   endtask

   task automatic release_all();
      b_cyc = '0; b_stb = '0; b_sack = '0;
      cycle();
      cycle();
   endtask

   initial begin
      int first_err;
      rst = 1'b1;
      b_cyc = '0; b_stb = '0; b_we = '0; b_sack = '0;
      for (int m = 0; m < NUM_M; m++) begin b_sel[m] = '0; b_adr[m] = '0; b_wdat[m] = '0; end
      for (int s = 0; s < NUM_S; s++) b_rdat[s] = 32'h1111_0000 + s;
      cycle();
      cycle();
      rst = 1'b0;

      // Read with two wait states from slave 1.
      b_rdat[1] = 32'hDEAD_BEEF;
      set_m(0, 1'b1, 1'b0, 4'hF, 32'h1000_0010, 32'h0);
      cycle();
      cycle();
      cycle();
      b_sack[1] = 1'b1;
      half();
      chk("rd_dat", m_dat_o[31:0], 32'hDEAD_BEEF);
      chk("rd_ack", m_ack_o, 2'b01);
      chk("rd_scyc", s_cyc_o, 4'b0010);
      edge_step();
      release_all();

      // Arbitration directly after reset.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
      set_m(1, 1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h0);
      cycle();
      half(); chk("arb_first", gnt_o, 2'b01); edge_step();
      b_cyc[0] = 1'b0; b_stb[0] = 1'b0;
      cycle();
      half(); chk("arb_idle", gnt_o, 2'b00); edge_step();
      half(); chk("arb_second", gnt_o, 2'b10); edge_step();
      b_sack[2] = 1'b1;
      cycle();
      b_sack[2] = 1'b0;
      b_cyc[1] = 1'b0; b_stb[1] = 1'b0;
      cycle();
      set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
      set_m(1, 1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h0);
      cycle();
      half(); chk("arb_third", gnt_o, 2'b01); edge_step();
      release_all();

      // Decode error from master 1.
      set_m(1, 1'b1, 1'b0, 4'hF, 32'hF000_0000, 32'h0);
      cycle();
      half(); chk("dec_scyc", s_cyc_o, 4'b0000); chk("dec_err0", m_err_o, 2'b00); edge_step();
      half(); chk("dec_err1", m_err_o, 2'b10); chk("dec_ack", m_ack_o, 2'b00); edge_step();
      cycle();
      cycle();
      release_all();

      // Hung slave 2; the watchdog fires only when it is compiled in.
      set_m(0, 1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h0);
      cycle();
      first_err = -1;
      for (int k = 0; k < 1000; k++) begin
         half();
         if (m_err_o[0] && first_err < 0) first_err = k;
         edge_step();
      end
`ifdef WB_BUS_TIMEOUT_EN
      chk("timeout_at", first_err, TIMEOUT);
`else
      chk("no_timeout", first_err, -1);
`endif
      release_all();

      // Byte write to slave 0.
      set_m(0, 1'b1, 1'b1, 4'b0100, 32'h0000_0004, 32'h00AB_0000);
      cycle();
      half();
      chk("bw_sel", s_sel_o, 4'b0100);
      chk("bw_we", s_we_o, 1'b1);
      chk("bw_dat", s_dat_o, 32'h00AB_0000);
      chk("bw_scyc", s_cyc_o, 4'b0001);
      edge_step();
      b_sack[0] = 1'b1;
      cycle();
      release_all();

      // Reset while slave 0 is acking.
      set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
      cycle();
      rst = 1'b1; b_sack[0] = 1'b1;
      half(); chk("rst_ack", m_ack_o, 2'b00); edge_step();
      rst = 1'b0; b_cyc = '0; b_stb = '0; b_sack = '0;
      half(); chk("rst_gnt", gnt_o, 2'b00); edge_step();
      set_m(1, 1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'h0);
      cycle();
      half(); chk("rst_m1", gnt_o, 2'b10); edge_step();
      release_all();

      // Random traffic, including occasional resets and decode errors.
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         for (int m = 0; m < NUM_M; m++) begin
            if (!b_cyc[m]) begin
               if ($urandom_range(0, 2) == 0)
                  set_m(m, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        {4'($urandom_range(0, 5)), 28'($urandom)}, $urandom);
            end else if ($urandom_range(0, 3) == 0) begin
               b_cyc[m] = 1'b0; b_stb[m] = 1'b0;
            end
         end
         b_sack = 4'($urandom_range(0, 15));
         for (int s = 0; s < NUM_S; s++) b_rdat[s] = $urandom;
         cycle();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_shared_bus.md
Name: wb_shared_bus

Overview:
- Parametrised Wishbone B3 classic shared-bus interconnect for the SOPC.
- Connects NUM_M masters (e.g. CPU ibus/dbus, future DMA) to NUM_S slaves (inst ROM, data RAM, timer, UART, ...).
- Provides round-robin arbitration, fixed address decode on top address nibble, decode-error response and optional watchdog timeout.
- Replaces the point-to-point ROM/RAM wiring at the SOPC top.

Parameters:
- NUM_M, 2, number of masters (1..8)
- NUM_S, 4, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width; SW = DW/8 byte selects (derived, not overridable)
- TIMEOUT, 255, cycles of stb without ack/err before forced err (1..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- m_cyc_i  in  NUM_M  master cycle, bit m = master m
- m_stb_i  in  NUM_M  master strobe
- m_we_i  in  NUM_M  master write enable
- m_sel_i  in  NUM_M*SW  byte selects, master m at [m*SW +: SW]
- m_adr_i  in  NUM_M*AW  addresses, packed likewise
- m_dat_i  in  NUM_M*DW  write data from masters
- m_dat_o  out  NUM_M*DW  read data to masters
- m_ack_o  out  NUM_M  ack to masters
- m_err_o  out  NUM_M  error to masters
- s_cyc_o  out  NUM_S  slave cycle, bit s = slave s
- s_stb_o  out  NUM_S  slave strobe
- s_we_o  out  1  shared write enable
- s_sel_o  out  SW  shared byte selects
- s_adr_o  out  AW  shared address
- s_dat_o  out  DW  shared write data
- s_dat_i  in  NUM_S*DW  read data from slaves
- s_ack_i  in  NUM_S  slave acks
- gnt_o  out  NUM_M  one-hot current grant (status/debug)

Behaviour:
- FSM states: IDLE, GRANT. Reset: IDLE, gnt_o = 0, round-robin pointer = 0, timeout counter = 0.
- IDLE: if any m_cyc_i is set, register grant to the first requesting master at or after the pointer, wrapping from NUM_M-1 to 0. Go to GRANT next cycle. Grant latency is 1 cycle from cyc.
- GRANT: hold while the granted master's cyc is high. When it drops, go to IDLE next cycle, clear gnt_o, and set the pointer to (granted+1) mod NUM_M. No back-to-back grant without an IDLE cycle.
- Decode: slave index = adr[AW-1:AW-4] of the granted master. Only that slave sees s_cyc_o/s_stb_o (granted cyc/stb, combinational). All other slaves stay 0.
- Shared s_we_o/s_sel_o/s_adr_o/s_dat_o mux the granted master combinationally. They are 0 when no grant.
- Return path: m_ack_o[g] = s_ack_i[idx] & stb. m_dat_o[g] = s_dat_i[idx]. Non-granted masters get ack = 0, err = 0, dat = 0. Response is combinational, zero added latency.
- Decode error: if idx >= NUM_S, no slave is strobed. m_err_o[g] pulses for 1 cycle, one cycle after stb is seen (registered). It re-pulses every other cycle while stb stays high.
- ack and err are never asserted together for the same master.
- Non-granted masters' requests are ignored; they wait with cyc/stb held.
- Reset mid-transfer: all of s_cyc_o, s_stb_o, m_ack_o, m_err_o and gnt_o read 0 in the cycle rst is sampled, overriding slave acks. FSM goes to IDLE and the pointer to 0.
- Every output is 0 during reset.

Optional Feature:
- Macro: WB_BUS_TIMEOUT_EN.
- Defined:
  - 16-bit counter increments each cycle the granted stb is high with no ack/err.
  - It clears on ack, err, stb low or grant change.
  - When the counter reaches TIMEOUT, m_err_o[g] pulses 1 cycle (registered) and the counter clears.
  - The slave's stb stays driven; the master must drop cyc.
- Undefined:
  - No counter logic.
  - A hung slave holds the bus indefinitely.
  - err is produced by decode error only.

Test Plan:
- Read, NUM_S=4: m0 reads 0x1000_0010, slave 1 acks after 2 wait states with 0xDEADBEEF -> m_dat_o[m0] = 0xDEADBEEF with m_ack_o[0] in the same cycle; only s_cyc_o[1] is high; m_ack_o[1] stays 0.
- Arbitration: m0 and m1 both raise cyc in the first cycle after reset -> gnt_o = 01 next cycle. m0 drops cyc -> IDLE 1 cycle, then gnt_o = 10. Both re-request after m1 finishes -> gnt_o = 01.
- Decode error: m1 accesses 0xF000_0000 with NUM_S=4 -> s_cyc_o = 0000; m_err_o[1] = 1 exactly one cycle after stb; m_ack_o = 0.
- Timeout (macro defined, TIMEOUT=16): slave 2 never acks -> m_err_o pulses 16 cycles after stb rises. Same stimulus with the macro undefined -> no err after 1000 cycles.
- Byte write: m0 writes 0x0000_0004 with sel = 4'b0100, data 0x00AB0000 -> s_sel_o = 0100, s_we_o = 1, s_dat_o = 0x00AB0000 on slave 0.
- Reset mid-transfer: rst asserted while slave 0 drives ack -> m_ack_o = 0 in that cycle; gnt_o = 0 next cycle; after release a new m1 request is granted via IDLE (pointer back at 0, m1 is the only requester).
